// File: rtl/am_param_search_pkg.sv
// -----------------------------------------------------------------------------
// am_pkg
//   Shared definitions for the associative-memory search engine:
//   - default geometry constants (hypervector width, dims per cycle, classes)
//   - the engine state encoding am_state_t
//   - width helpers for similarity, class index and segment counters
//   Optional feature macro used by the engine: AM_PRUNE_EN.
// -----------------------------------------------------------------------------
package am_pkg;

    localparam int AM_HV_DIM_DEF      = 4096;
    localparam int AM_DIMS_PER_CC_DEF = 1024;
    localparam int AM_NUM_CLASSES_DEF = 26;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } am_state_t;

    // Enough bits to hold a popcount of hv_dim ones.
    function automatic int sim_w(input int hv_dim);
        return $clog2(hv_dim + 1);
    endfunction

    // Class index width; at least one bit.
    function automatic int class_w(input int num_classes);
        return (num_classes > 1) ? $clog2(num_classes) : 1;
    endfunction

    // Segment counter width; at least one bit even for a single segment.
    function automatic int seg_w(input int segments);
        return (segments > 1) ? $clog2(segments) : 1;
    endfunction

endpackage

// File: rtl/am_param_search_if.sv
// -----------------------------------------------------------------------------
// am_param_search_if
//   Query / result handshake bundle of the associative-memory search engine.
//   Signals:
//     query_valid, query_ready, query_hv   - query handshake and payload
//     prune_mask                           - kept-dimension mask (AM_PRUNE_EN)
//     result_valid, result_ready           - result handshake
//     class_inference, best_similarity,
//     margin                               - result payload
//   Modports:
//     master - query producer / result consumer
//     slave  - the search engine
// -----------------------------------------------------------------------------
interface am_param_search_if
    import am_pkg::*;
#(
    parameter int HV_DIM      = AM_HV_DIM_DEF,
    parameter int NUM_CLASSES = AM_NUM_CLASSES_DEF
);
    localparam int SIM_W   = sim_w(HV_DIM);
    localparam int CLASS_W = class_w(NUM_CLASSES);

    logic               query_valid;
    logic               query_ready;
    logic [HV_DIM-1:0]  query_hv;
`ifdef AM_PRUNE_EN
    logic [HV_DIM-1:0]  prune_mask;
`endif
    logic               result_valid;
    logic               result_ready;
    logic [CLASS_W-1:0] class_inference;
    logic [SIM_W-1:0]   best_similarity;
    logic [SIM_W-1:0]   margin;

    modport master (
`ifdef AM_PRUNE_EN
        output prune_mask,
`endif
        output query_valid,
        output query_hv,
        output result_ready,
        input  query_ready,
        input  result_valid,
        input  class_inference,
        input  best_similarity,
        input  margin
    );

    modport slave (
`ifdef AM_PRUNE_EN
        input  prune_mask,
`endif
        input  query_valid,
        input  query_hv,
        input  result_ready,
        output query_ready,
        output result_valid,
        output class_inference,
        output best_similarity,
        output margin
    );

endinterface

// File: rtl/am_param_search_segment_popcount.sv
// -----------------------------------------------------------------------------
// am_segment_popcount
//   Combinational similarity of one segment: popcount(query_seg & class_seg).
//   Ports:
//     query_seg  in  DIMS_PER_CC  - query bits of the current segment
//     class_seg  in  DIMS_PER_CC  - class bits of the same segment
//     count      out CNT_W        - number of positions set in both
// -----------------------------------------------------------------------------
module am_segment_popcount
    import am_pkg::*;
#(
    parameter int DIMS_PER_CC = AM_DIMS_PER_CC_DEF,
    parameter int CNT_W       = sim_w(DIMS_PER_CC)
) (
    input  logic [DIMS_PER_CC-1:0] query_seg,
    input  logic [DIMS_PER_CC-1:0] class_seg,
    output logic [CNT_W-1:0]       count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DIMS_PER_CC; i++) begin
            count = count + CNT_W'(query_seg[i] & class_seg[i]);
        end
    end

endmodule

// File: rtl/am_param_search.sv
// -----------------------------------------------------------------------------
// am_param_search
//   Associative-memory search for the sparse HDC classifier. A query accepted
//   in IDLE is streamed against every class hypervector DIMS_PER_CC dims per
//   cycle (ACCUM), then a one-class-per-cycle argmax (COMPARE) produces the
//   winning class, its similarity and the margin to the runner-up (DONE).
//   Ports:
//     clk        in  - rising-edge clock
//     rst        in  - asynchronous active-high reset, clears all state
//     class_hvs  in  - NUM_CLASSES*HV_DIM class vectors, class c at
//                      [c*HV_DIM +: HV_DIM]; static from accept to result
//     bus        slave modport of am_param_search_if (query/result handshake)
//   Optional feature: AM_PRUNE_EN adds prune_mask; masked-out dimensions are
//   ignored and segments with no kept dimension take no ACCUM cycle.
// -----------------------------------------------------------------------------
module am_param_search
    import am_pkg::*;
#(
    parameter int HV_DIM      = AM_HV_DIM_DEF,
    parameter int DIMS_PER_CC = AM_DIMS_PER_CC_DEF,
    parameter int NUM_CLASSES = AM_NUM_CLASSES_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CLASSES*HV_DIM-1:0] class_hvs,
    am_param_search_if.slave              bus
);

    localparam int SEGMENTS = HV_DIM / DIMS_PER_CC;
    localparam int SIM_W    = sim_w(HV_DIM);
    localparam int CLASS_W  = class_w(NUM_CLASSES);
    localparam int SEG_W    = seg_w(SEGMENTS);
    localparam int CNT_W    = sim_w(DIMS_PER_CC);

    localparam logic [SEG_W-1:0]   LAST_SEG   = SEG_W'(SEGMENTS - 1);
    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

    am_state_t          state_q, state_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [HV_DIM-1:0]  query_q, query_d;
    logic [SIM_W-1:0]   acc_q [NUM_CLASSES];
    logic [SIM_W-1:0]   acc_d [NUM_CLASSES];
    logic [CLASS_W-1:0] cmp_idx_q, cmp_idx_d;
    logic [SIM_W-1:0]   best_q, best_d;
    logic [SIM_W-1:0]   second_q, second_d;
    logic [CLASS_W-1:0] best_idx_q, best_idx_d;
    logic               query_ready_q, query_ready_d;
    logic               result_valid_q, result_valid_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [SIM_W-1:0]   best_sim_q, best_sim_d;
    logic [SIM_W-1:0]   margin_q, margin_d;

    // Argmax step for the class currently under comparison.
    logic [SIM_W-1:0]   cand;
    logic [SIM_W-1:0]   step_best;
    logic [SIM_W-1:0]   step_second;
    logic [CLASS_W-1:0] step_idx;

`ifdef AM_PRUNE_EN
    logic [HV_DIM-1:0]  mask_q, mask_d;
    logic [SEG_W:0]     seg_pick;   // {found, index}

    // One bit per segment: does the mask keep any dimension of it?
    function automatic logic [SEGMENTS-1:0] seg_active(input logic [HV_DIM-1:0] m);
        logic [SEGMENTS-1:0] r;
        for (int k = 0; k < SEGMENTS; k++) begin
            r[k] = |m[k*DIMS_PER_CC +: DIMS_PER_CC];
        end
        return r;
    endfunction

    // Lowest active segment with index >= start, as {found, index}.
    function automatic logic [SEG_W:0] find_from(input logic [SEGMENTS-1:0] act,
                                                 input int start);
        logic [SEG_W:0] r;
        r = '0;
        for (int k = SEGMENTS - 1; k >= 0; k--) begin
            if (act[k] && (k >= start)) begin
                r = {1'b1, SEG_W'(k)};
            end
        end
        return r;
    endfunction
`endif

    // Per-class segment similarity of the current segment.
    logic [DIMS_PER_CC-1:0] query_seg;
    logic [CNT_W-1:0]       seg_pop [NUM_CLASSES];

    assign query_seg = query_q[int'(seg_q)*DIMS_PER_CC +: DIMS_PER_CC];

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pop
        am_segment_popcount #(
            .DIMS_PER_CC (DIMS_PER_CC),
            .CNT_W       (CNT_W)
        ) u_pop (
            .query_seg (query_seg),
            .class_seg (class_hvs[c*HV_DIM + int'(seg_q)*DIMS_PER_CC +: DIMS_PER_CC]),
            .count     (seg_pop[c])
        );
    end

    always_comb begin
        state_d        = state_q;
        seg_d          = seg_q;
        query_d        = query_q;
        cmp_idx_d      = cmp_idx_q;
        best_d         = best_q;
        second_d       = second_q;
        best_idx_d     = best_idx_q;
        query_ready_d  = query_ready_q;
        result_valid_d = result_valid_q;
        class_d        = class_q;
        best_sim_d     = best_sim_q;
        margin_d       = margin_q;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_d[c] = acc_q[c];
        end
`ifdef AM_PRUNE_EN
        mask_d   = mask_q;
        seg_pick = '0;
`endif

        // Strictly-greater replaces the best, so ties keep the lower index;
        // the displaced best becomes the runner-up.
        cand        = acc_q[cmp_idx_q];
        step_best   = best_q;
        step_second = second_q;
        step_idx    = best_idx_q;
        if (cand > best_q) begin
            step_best   = cand;
            step_idx    = cmp_idx_q;
            step_second = best_q;
        end else if (cand > second_q) begin
            step_second = cand;
        end

        case (state_q)
            IDLE: begin
                if (bus.query_valid) begin
                    query_ready_d = 1'b0;
                    cmp_idx_d     = '0;
                    best_d        = '0;
                    second_d      = '0;
                    best_idx_d    = '0;
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        acc_d[c] = '0;
                    end
`ifdef AM_PRUNE_EN
                    query_d  = bus.query_hv & bus.prune_mask;
                    mask_d   = bus.prune_mask;
                    seg_pick = find_from(seg_active(bus.prune_mask), 0);
                    seg_d    = seg_pick[SEG_W-1:0];
                    // A fully masked query has nothing to accumulate.
                    state_d  = seg_pick[SEG_W] ? ACCUM : COMPARE;
`else
                    query_d  = bus.query_hv;
                    seg_d    = '0;
                    state_d  = ACCUM;
`endif
                end
            end

            ACCUM: begin
                for (int c = 0; c < NUM_CLASSES; c++) begin
                    acc_d[c] = acc_q[c] + SIM_W'(seg_pop[c]);
                end
`ifdef AM_PRUNE_EN
                seg_pick = find_from(seg_active(mask_q), int'(seg_q) + 1);
                seg_d    = seg_pick[SEG_W-1:0];
                if (!seg_pick[SEG_W]) begin
                    state_d = COMPARE;
                end
`else
                if (seg_q == LAST_SEG) begin
                    state_d = COMPARE;
                end else begin
                    seg_d = seg_q + SEG_W'(1);
                end
`endif
            end

            COMPARE: begin
                best_d     = step_best;
                second_d   = step_second;
                best_idx_d = step_idx;
                cmp_idx_d  = cmp_idx_q + CLASS_W'(1);
                if (cmp_idx_q == LAST_CLASS) begin
                    class_d        = step_idx;
                    best_sim_d     = step_best;
                    margin_d       = step_best - step_second;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end

            DONE: begin
                if (bus.result_ready) begin
                    result_valid_d = 1'b0;
                    query_ready_d  = 1'b1;
                    state_d        = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            seg_q          <= '0;
            query_q        <= '0;
            cmp_idx_q      <= '0;
            best_q         <= '0;
            second_q       <= '0;
            best_idx_q     <= '0;
            query_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            class_q        <= '0;
            best_sim_q     <= '0;
            margin_q       <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                acc_q[c] <= '0;
            end
`ifdef AM_PRUNE_EN
            mask_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            seg_q          <= seg_d;
            query_q        <= query_d;
            cmp_idx_q      <= cmp_idx_d;
            best_q         <= best_d;
            second_q       <= second_d;
            best_idx_q     <= best_idx_d;
            query_ready_q  <= query_ready_d;
            result_valid_q <= result_valid_d;
            class_q        <= class_d;
            best_sim_q     <= best_sim_d;
            margin_q       <= margin_d;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                acc_q[c] <= acc_d[c];
            end
`ifdef AM_PRUNE_EN
            mask_q         <= mask_d;
`endif
        end
    end

    assign bus.query_ready     = query_ready_q;
    assign bus.result_valid    = result_valid_q;
    assign bus.class_inference = class_q;
    assign bus.best_similarity = best_sim_q;
    assign bus.margin          = margin_q;

endmodule

// File: tb/tb_am_param_search.sv
// -----------------------------------------------------------------------------
// tb_am_param_search
//   Directed bench for am_param_search at the default geometry
//   (4096 dims, 1024 dims/cycle, 26 classes). Prune scenarios are compiled
//   in when AM_PRUNE_EN is defined.
// -----------------------------------------------------------------------------
module tb_am_param_search;

    localparam int HV = 4096;
    localparam int DC = 1024;
    localparam int NC = 26;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC*HV-1:0] class_hvs;

    int n_run  = 0;
    int n_fail = 0;

    am_param_search_if #(.HV_DIM(HV), .NUM_CLASSES(NC)) bus ();

    am_param_search #(
        .HV_DIM      (HV),
        .DIMS_PER_CC (DC),
        .NUM_CLASSES (NC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .class_hvs (class_hvs),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [HV-1:0] ones_low(input int n);
        logic [HV-1:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic accept_query(input logic [HV-1:0] hv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.query_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            bus.query_hv    = hv;
            bus.query_valid = 1'b1;
            @(posedge clk);
            #1 bus.query_valid = 1'b0;
        end
    endtask

    // Edges after the accepting edge until result_valid is seen; -1 on timeout.
    task automatic wait_result(output int edges);
        edges = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic take_result();
        @(negedge clk) bus.result_ready = 1'b1;
        @(posedge clk);
        #1 bus.result_ready = 1'b0;
    endtask

    task automatic run_query(input string name, input logic [HV-1:0] hv,
                             input int exp_lat, input int exp_cls,
                             input int exp_best, input int exp_margin);
        bit ok;
        int lat;
        accept_query(hv, ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_accept: query_ready never high", name);
        end
        wait_result(lat);
        n_run++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges, expected %0d", name, lat, exp_lat);
        end
        n_run++;
        if (bus.class_inference !== 5'(exp_cls)) begin
            n_fail++;
            $display("FAIL %s_class: got %0d, expected %0d", name, bus.class_inference, exp_cls);
        end
        n_run++;
        if (bus.best_similarity !== 13'(exp_best)) begin
            n_fail++;
            $display("FAIL %s_best: got %0d, expected %0d", name, bus.best_similarity, exp_best);
        end
        n_run++;
        if (bus.margin !== 13'(exp_margin)) begin
            n_fail++;
            $display("FAIL %s_margin: got %0d, expected %0d", name, bus.margin, exp_margin);
        end
        take_result();
    endtask

    task automatic check_reset_values(input string name);
        n_run++;
        if ({bus.query_ready, bus.result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_handshake: query_ready=%b result_valid=%b, expected 1/0",
                     name, bus.query_ready, bus.result_valid);
        end
        n_run++;
        if (bus.class_inference !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_class: got %0d, expected 0", name, bus.class_inference);
        end
        n_run++;
        if (bus.best_similarity !== 13'd0) begin
            n_fail++;
            $display("FAIL %s_best: got %0d, expected 0", name, bus.best_similarity);
        end
        n_run++;
        if (bus.margin !== 13'd0) begin
            n_fail++;
            $display("FAIL %s_margin: got %0d, expected 0", name, bus.margin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.query_valid  = 1'b0;
        bus.result_ready = 1'b0;
        bus.query_hv     = '0;
`ifdef AM_PRUNE_EN
        bus.prune_mask   = '1;
`endif
        class_hvs = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_single_winner();
        class_hvs = '0;
        class_hvs[5*HV +: HV] = '1;
        run_query("single", '1, 30, 5, 4096, 4096);
    endtask

    task automatic test_reset_mid();
        bit ok;
        // Class 5 result from the previous test is still on the outputs.
        accept_query('1, ok);
        n_run++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_accept: query_ready never high");
        end
        @(posedge clk);
        #1;
        n_run++;
        if (bus.query_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_busy: query_ready=%b, expected 0", bus.query_ready);
        end
        @(posedge clk);          // segment 2 is now being accumulated
        #2 rst = 1'b1;
        #1 check_reset_values("rstmid");
        @(negedge clk) rst = 1'b0;
        class_hvs = '0;
        class_hvs[9*HV +: HV] = ones_low(300);
        class_hvs[1*HV +: HV] = ones_low(100);
        run_query("after_rst", '1, 30, 9, 300, 200);
    endtask

    task automatic test_tie();
        for (int c = 0; c < NC; c++) class_hvs[c*HV +: HV] = ones_low(100);
        class_hvs[3*HV +: HV] = ones_low(2000);
        class_hvs[7*HV +: HV] = ones_low(2000);
        run_query("tie", '1, 30, 3, 2000, 0);
    endtask

    task automatic test_zero_query();
        run_query("zeroq", '0, 30, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        class_hvs = '0;
        class_hvs[5*HV +: HV] = '1;
        accept_query('1, ok);
        wait_result(lat);
        n_run++;
        if (lat !== 30) begin
            n_fail++;
            $display("FAIL bp_latency: got %0d edges, expected 30", lat);
        end
        // Offer a second query while the result is held.
        @(negedge clk);
        bus.query_hv    = ones_low(1500);
        bus.query_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_run++;
            if ({bus.result_valid, bus.query_ready, bus.class_inference,
                 bus.best_similarity, bus.margin} !==
                {1'b1, 1'b0, 5'd5, 13'd4096, 13'd4096}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: rv=%b qr=%b cls=%0d best=%0d margin=%0d, expected 1 0 5 4096 4096",
                         i, bus.result_valid, bus.query_ready, bus.class_inference,
                         bus.best_similarity, bus.margin);
            end
        end
        @(negedge clk) bus.result_ready = 1'b1;
        @(posedge clk);
        #1 bus.result_ready = 1'b0;
        n_run++;
        if ({bus.result_valid, bus.query_ready, bus.class_inference} !== {1'b0, 1'b1, 5'd5}) begin
            n_fail++;
            $display("FAIL bp_release: rv=%b qr=%b cls=%0d, expected 0 1 5",
                     bus.result_valid, bus.query_ready, bus.class_inference);
        end
        @(posedge clk);
        #1 bus.query_valid = 1'b0;
        n_run++;
        if (bus.query_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accept: query_ready=%b, expected 0", bus.query_ready);
        end
        wait_result(lat);
        n_run++;
        if (lat !== 30) begin
            n_fail++;
            $display("FAIL bp2_latency: got %0d edges, expected 30", lat);
        end
        n_run++;
        if ({bus.class_inference, bus.best_similarity, bus.margin} !==
            {5'd5, 13'd1500, 13'd1500}) begin
            n_fail++;
            $display("FAIL bp2_result: cls=%0d best=%0d margin=%0d, expected 5 1500 1500",
                     bus.class_inference, bus.best_similarity, bus.margin);
        end
        take_result();
    endtask

    task automatic test_back_to_back();
        int rise1 = -1;
        int rise2 = -1;
        logic prev = 1'b0;
        class_hvs = '0;
        class_hvs[5*HV +: HV] = '1;
        @(negedge clk);
        bus.query_hv     = '1;
        bus.query_valid  = 1'b1;
        bus.result_ready = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid === 1'b1 && prev == 1'b0) begin
                if (rise1 < 0) rise1 = i;
                else rise2 = i;
            end
            prev = bus.result_valid;
            if (rise2 >= 0) break;
        end
        @(negedge clk) bus.query_valid = 1'b0;
        @(posedge clk);
        #1 bus.result_ready = 1'b0;
        n_run++;
        if (rise1 !== 31) begin
            n_fail++;
            $display("FAIL b2b_first: result at edge %0d, expected 31", rise1);
        end
        n_run++;
        if (rise2 - rise1 !== 32) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles, expected 32", rise2 - rise1);
        end
    endtask

`ifdef AM_PRUNE_EN
    task automatic test_prune();
        class_hvs = '0;
        class_hvs[2*HV +: HV] = '1;
        bus.prune_mask = ones_low(1024);
        run_query("prune1seg", '1, 27, 2, 1024, 1024);
        bus.prune_mask = '0;
        run_query("prune_all", '1, 26, 0, 0, 0);
        bus.prune_mask = '1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_winner();
        test_reset_mid();
        test_tie();
        test_zero_query();
        test_backpressure();
        test_back_to_back();
`ifdef AM_PRUNE_EN
        test_prune();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/am_param_search.md
# am_param_search

Parametrised associative-memory search engine for the sparse HDC classifier. It accepts one encoded query hypervector through a valid/ready handshake and streams it against all class hypervectors, `DIMS_PER_CC` dimensions per cycle, accumulating an AND-popcount similarity per class. A sequential argmax then returns the winning class, its similarity, and the margin to the runner-up. It replaces the fixed 4096-dim / 26-class / 4-cycle search in the AM path and adds output back-pressure, margin reporting, and optional dimension pruning.

## Interface
- `HV_DIM`, 4096, hypervector width; must be a multiple of `DIMS_PER_CC`
- `DIMS_PER_CC`, 1024, dimensions processed per accumulate cycle
- `NUM_CLASSES`, 26, number of class hypervectors; ≥ 2
- Derived: `SEGMENTS = HV_DIM/DIMS_PER_CC`, `SIM_W = $clog2(HV_DIM+1)`, `CLASS_W = $clog2(NUM_CLASSES)`

- `clk` in 1 — single clock, rising edge
- `rst` in 1 — reset; asynchronous, active-high
- `query_valid` in 1 — query present
- `query_ready` out 1 — engine idle, can accept a query
- `query_hv` in `HV_DIM` — encoded query; sampled on the accepting edge only
- `class_hvs` in `NUM_CLASSES*HV_DIM` — class c occupies bits [c*HV_DIM +: HV_DIM]; must be static from accept to result
- `prune_mask` in `HV_DIM` — 1 = dimension kept (only with `AM_PRUNE_EN`)
- `result_valid` out 1 — result available
- `result_ready` in 1 — consumer takes result
- `class_inference` out `CLASS_W` — winning class index
- `best_similarity` out `SIM_W` — winner's similarity
- `margin` out `SIM_W` — best minus second-best similarity

## Operation
- States: IDLE → ACCUM → COMPARE → DONE → IDLE.
- **IDLE**
  - `query_ready`=1.
  - On `query_valid`: register `query_hv` (and `prune_mask`), clear all accumulators and the segment counter, go to ACCUM.
- **ACCUM**
  - Each cycle processes segment k = bits [k*DIMS_PER_CC +: DIMS_PER_CC].
  - For each class: acc[c] += popcount(query_seg & class_seg[c]).
  - After segment `SEGMENTS-1`, go to COMPARE.
- **COMPARE**
  - One class per cycle, index 0..NUM_CLASSES-1.
  - Track best and second-best values.
  - Replace best only on strictly greater; ties keep the lower index.
  - A demoted best becomes second-best.
  - After the last class, latch the outputs and go to DONE.
- **DONE**
  - `result_valid`=1; outputs held stable.
  - On `result_ready`: go to IDLE.
- Arithmetic: accumulators are `SIM_W` bits unsigned; no overflow possible. `margin` = best − second, always ≥ 0.
- `query_ready` is 0 outside IDLE. A query offered during DONE is not accepted until the cycle after the result handshake (one bubble).
- `rst` mid-operation: aborts immediately, returns to IDLE, clears all state.
- Reset values: `query_ready`=1, `result_valid`=0, `class_inference`=0, `best_similarity`=0, `margin`=0.

## Timing
- Accepting edge e0.
- ACCUM occupies edges e1..eSEGMENTS; COMPARE occupies the next NUM_CLASSES edges.
- `result_valid` rises after edge e(SEGMENTS+NUM_CLASSES): 30 edges at the defaults.
- Throughput: one query per SEGMENTS+NUM_CLASSES+2 cycles when `result_ready` is held high.
- Outputs change only on the edge entering DONE, or on reset.

## Configuration
- `AM_PRUNE_EN` defined:
  - `prune_mask` port exists; it is ANDed into every segment before popcount.
  - Segments whose mask bits are all zero are skipped (no ACCUM cycle). Latency = active segments + NUM_CLASSES.
  - All-zero mask: ACCUM is skipped entirely; result is class 0, similarity 0, margin 0.
- `AM_PRUNE_EN` undefined:
  - No `prune_mask` port; all segments are processed; latency is fixed.

## Structure
- Package `am_pkg`:
  - default parameter constants;
  - state enum `am_state_t` (IDLE, ACCUM, COMPARE, DONE);
  - `SIM_W`/`CLASS_W` helper functions.
- Sub-module `am_segment_popcount`: combinational AND plus popcount of one `DIMS_PER_CC` segment against one class. Instantiated `NUM_CLASSES` times.

## Test plan
- Class 5 all ones, others zero; query all ones → class 5, best 4096, margin 4096; `result_valid` 30 edges after accept.
- Classes 3 and 7 identical and highest (2000), others 100 → class 3, best 2000, margin 0.
- All-zero query → class 0, best 0, margin 0.
- `result_ready` held low 10 cycles in DONE → outputs stable, `query_ready`=0, new query not accepted; release → IDLE next edge, accept on the following edge.
- `rst` pulsed during ACCUM segment 2 → all outputs at reset values; `query_ready`=1; next query produces a correct result.
- `AM_PRUNE_EN`, mask = ones only in bits 0..1023, query and class 2 all ones → class 2, best 1024; latency 27 edges.
